// File: rtl/shift_reg_sequencer_if.sv
// Command / completion bundle between a host and shift_reg_sequencer.
// The host side uses the master modport and the sequencer uses the slave modport.
interface shift_reg_sequencer_if #(
    parameter int N  = 8,
    parameter int CW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_cnt;
    logic [N-1:0]  cmd_data;
    logic          cmd_sin;
    logic          busy;
    logic          done;
    logic          err;
    logic [N-1:0]  result;
    logic [N-1:0]  cap;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_sin,
        input  cmd_ready, busy, done, err, result, cap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_sin,
        output cmd_ready, busy, done, err, result, cap
    );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Command sequencer driving one N-bit multi-function shift register and capturing its serial output.
// Optional feature macro: SEQ_ROTATE_EN (op 7 becomes rotate-left; otherwise op 7 is illegal).
module shift_reg_sequencer #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    shift_reg_sequencer_if.slave   cmd,
    output logic [N-1:0]           reg_din,
    output logic                   reg_ld,
    output logic                   reg_clr,
    output logic                   reg_shift_l,
    output logic                   reg_shift_r,
    output logic                   reg_a_shift,
    output logic                   reg_shift_in,
    input  logic [N-1:0]           reg_dout,
    input  logic                   reg_shift_out
);
    localparam logic [2:0]    OP_CLR  = 3'd1;
    localparam logic [2:0]    OP_LOAD = 3'd2;
    localparam logic [2:0]    OP_SHL  = 3'd3;
    localparam logic [2:0]    OP_SHR  = 3'd4;
    localparam logic [2:0]    OP_ASR  = 3'd5;
    localparam logic [2:0]    OP_RSV  = 3'd6;
    localparam logic [2:0]    OP_ROL  = 3'd7;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_SHIFT = 3'd2,
        S_FIN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [2:0]    op_r;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  data_r;
    logic          sin_r;
    logic [N-1:0]  cap_r;
    logic [N-1:0]  result_r;
    logic          err_r;
    logic          cap_en_r;

    function automatic logic op_is_shift(input logic [2:0] op);
        logic r;
        r = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
`ifdef SEQ_ROTATE_EN
        r = r || (op == OP_ROL);
`endif
        return r;
    endfunction

    function automatic logic op_is_illegal(input logic [2:0] op);
`ifdef SEQ_ROTATE_EN
        return (op == OP_RSV);
`else
        return (op == OP_RSV) || (op == OP_ROL);
`endif
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (clr) state_r <= S_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    if ((cmd.cmd_op == OP_CLR) || (cmd.cmd_op == OP_LOAD))
                        state_nxt_s = S_EXEC;
                    else if (op_is_shift(cmd.cmd_op) && (cmd.cmd_cnt != {CW{1'b0}}))
                        state_nxt_s = S_SHIFT;
                    else
                        state_nxt_s = S_FIN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_EXEC:  state_nxt_s = S_FIN;
            S_SHIFT: begin
                if (cnt_r == CNT_ONE) state_nxt_s = S_FIN;
                else                  state_nxt_s = S_SHIFT;
            end
            S_FIN:   state_nxt_s = S_DONE;
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode; reset forces a register clear alongside the controller
    always_comb begin
        reg_din       = {N{1'b0}};
        reg_ld        = 1'b0;
        reg_clr       = 1'b0;
        reg_shift_l   = 1'b0;
        reg_shift_r   = 1'b0;
        reg_a_shift   = 1'b0;
        reg_shift_in  = 1'b0;
        cmd.cmd_ready = 1'b0;
        cmd.busy      = 1'b0;
        cmd.done      = 1'b0;
        cmd.err       = 1'b0;
        if (clr) begin
            reg_clr = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: cmd.cmd_ready = 1'b1;
                S_EXEC: begin
                    cmd.busy = 1'b1;
                    if (op_r == OP_CLR) begin
                        reg_clr = 1'b1;
                    end else begin
                        reg_ld  = 1'b1;
                        reg_din = data_r;
                    end
                end
                S_SHIFT: begin
                    cmd.busy = 1'b1;
                    case (op_r)
                        OP_SHL: begin reg_shift_l = 1'b1; reg_shift_in = sin_r; end
                        OP_SHR: begin reg_shift_r = 1'b1; reg_shift_in = sin_r; end
                        OP_ASR: begin reg_a_shift = 1'b1; reg_shift_in = sin_r; end
`ifdef SEQ_ROTATE_EN
                        OP_ROL: begin reg_shift_l = 1'b1; reg_shift_in = reg_dout[N-1]; end
`endif
                        default: reg_shift_in = 1'b0;
                    endcase
                end
                S_FIN: cmd.busy = 1'b1;
                S_DONE: begin
                    cmd.busy = 1'b1;
                    cmd.done = 1'b1;
                    cmd.err  = err_r;
                end
                default: cmd.busy = 1'b0;
            endcase
        end
    end

    // Command latch, shift counter, serial capture and result snapshot
    always_ff @(posedge clk) begin
        if (clr) begin
            op_r     <= 3'd0;
            cnt_r    <= {CW{1'b0}};
            data_r   <= {N{1'b0}};
            sin_r    <= 1'b0;
            cap_r    <= {N{1'b0}};
            result_r <= {N{1'b0}};
            err_r    <= 1'b0;
            cap_en_r <= 1'b0;
        end else begin
            // The register presents a shifted-out bit one cycle after the shift strobe
            cap_en_r <= (state_r == S_SHIFT);
            if (cap_en_r) begin
                if ((op_r == OP_SHL) || (op_r == OP_ROL))
                    cap_r <= {cap_r[N-2:0], reg_shift_out};
                else
                    cap_r <= {reg_shift_out, cap_r[N-1:1]};
            end
            case (state_r)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_r   <= cmd.cmd_op;
                        cnt_r  <= cmd.cmd_cnt;
                        data_r <= cmd.cmd_data;
                        sin_r  <= cmd.cmd_sin;
                        cap_r  <= {N{1'b0}};
                    end
                end
                S_SHIFT: cnt_r <= cnt_r - CNT_ONE;
                S_FIN: begin
                    result_r <= reg_dout;
                    err_r    <= op_is_illegal(op_r);
                end
                default: err_r <= err_r;
            endcase
        end
    end

    assign cmd.result = result_r;
    assign cmd.cap    = cap_r;
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed self-checking bench for shift_reg_sequencer with a behavioural model of the shift register.
module tb_shift_reg_sequencer;
    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] reg_din;
    logic       reg_ld, reg_clr, reg_shift_l, reg_shift_r, reg_a_shift, reg_shift_in;
    logic [7:0] reg_dout = 8'h00;
    logic       reg_shift_out = 1'b0;

    int checks   = 0;
    int failures = 0;
    int lat;
    logic [7:0] got_result, got_cap;
    logic       got_err;
    logic       multi_ctrl_seen = 1'b0;

    shift_reg_sequencer_if #(.N(8), .CW(4)) bus ();

    shift_reg_sequencer #(.N(8), .CW(4)) dut (
        .clk(clk), .clr(clr), .cmd(bus.slave),
        .reg_din(reg_din), .reg_ld(reg_ld), .reg_clr(reg_clr),
        .reg_shift_l(reg_shift_l), .reg_shift_r(reg_shift_r), .reg_a_shift(reg_a_shift),
        .reg_shift_in(reg_shift_in), .reg_dout(reg_dout), .reg_shift_out(reg_shift_out)
    );

    always #5 clk = ~clk;

    // Behavioural model of the attached multi-function shift register
    always @(posedge clk) begin
        if (reg_clr) begin
            reg_dout <= 8'h00; reg_shift_out <= 1'b0;
        end else if (reg_ld) begin
            reg_dout <= reg_din;
        end else if (reg_shift_l) begin
            reg_dout <= {reg_dout[6:0], reg_shift_in}; reg_shift_out <= reg_dout[7];
        end else if (reg_shift_r) begin
            reg_dout <= {reg_shift_in, reg_dout[7:1]}; reg_shift_out <= reg_dout[0];
        end else if (reg_a_shift) begin
            reg_dout <= {reg_dout[7], reg_dout[7:1]}; reg_shift_out <= reg_dout[0];
        end
    end

    always @(negedge clk)
        if ($countones({reg_ld, reg_clr, reg_shift_l, reg_shift_r, reg_a_shift}) > 1)
            multi_ctrl_seen = 1'b1;

    // Issue one command from an idle controller and wait (bounded) for done
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] cnt,
                           input logic [7:0] data, input logic sin);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_cnt = cnt;
        bus.cmd_data = data; bus.cmd_sin = sin;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd1; bus.cmd_cnt = ~cnt;
        bus.cmd_data = ~data; bus.cmd_sin = ~sin;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k; got_result = bus.result; got_cap = bus.cap; got_err = bus.err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_cnt = 4'd0;
        bus.cmd_data = 8'h00; bus.cmd_sin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            failures++; $display("FAIL reset_status got=%b exp=000", {bus.busy, bus.done, bus.err});
        end
        checks++;
        if ({bus.result, bus.cap} !== 16'h0000) begin
            failures++; $display("FAIL reset_data got=%h exp=0000", {bus.result, bus.cap});
        end
        checks++;
        if ({reg_clr, reg_ld, reg_shift_l, reg_shift_r, reg_a_shift, reg_shift_in, reg_din} !== {6'b100000, 8'h00}) begin
            failures++; $display("FAIL reset_reg_ctrl got=%b exp=10000000000000",
                                 {reg_clr, reg_ld, reg_shift_l, reg_shift_r, reg_a_shift, reg_shift_in, reg_din});
        end
        clr = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready);
        end
    endtask

    task automatic test_load_shr();
        run_cmd(3'd2, 4'd0, 8'hA5, 1'b0);
        checks++;
        if (lat !== 3 || got_result !== 8'hA5) begin
            failures++; $display("FAIL load_a5 got lat=%0d res=%h exp lat=3 res=a5", lat, got_result);
        end
        run_cmd(3'd4, 4'd8, 8'h00, 1'b0);
        checks++;
        if (lat !== 10) begin
            failures++; $display("FAIL shr8_latency got=%0d exp=10", lat);
        end
        checks++;
        if ({got_cap, got_result, got_err} !== {8'hA5, 8'h00, 1'b0}) begin
            failures++; $display("FAIL shr8_data got cap=%h res=%h err=%b exp cap=a5 res=00 err=0",
                                 got_cap, got_result, got_err);
        end
    endtask

    task automatic test_asr();
        run_cmd(3'd2, 4'd0, 8'h96, 1'b0);
        run_cmd(3'd5, 4'd3, 8'h00, 1'b0);
        checks++;
        if ({lat[7:0], got_result, got_cap} !== {8'd5, 8'hF2, 8'hC0}) begin
            failures++; $display("FAIL asr3 got lat=%0d res=%h cap=%h exp lat=5 res=f2 cap=c0",
                                 lat, got_result, got_cap);
        end
    endtask

    task automatic test_shl();
        run_cmd(3'd2, 4'd0, 8'h3C, 1'b0);
        run_cmd(3'd3, 4'd4, 8'h00, 1'b1);
        checks++;
        if ({lat[7:0], got_result, got_cap} !== {8'd6, 8'hCF, 8'h03}) begin
            failures++; $display("FAIL shl4 got lat=%0d res=%h cap=%h exp lat=6 res=cf cap=03",
                                 lat, got_result, got_cap);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd3; bus.cmd_cnt = 4'd0; bus.cmd_sin = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.done, bus.cmd_ready, bus.busy} !== 3'b001) begin
            failures++; $display("FAIL b2b_cycle1 got=%b exp=001", {bus.done, bus.cmd_ready, bus.busy});
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.cmd_ready, bus.result, bus.cap} !== {2'b10, 8'hCF, 8'h00}) begin
            failures++; $display("FAIL b2b_done got done=%b rdy=%b res=%h cap=%h exp 1 0 cf 00",
                                 bus.done, bus.cmd_ready, bus.result, bus.cap);
        end
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
            failures++; $display("FAIL b2b_ready_after_done got=%b exp=10", {bus.cmd_ready, bus.busy});
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b01) begin
            failures++; $display("FAIL b2b_second_busy got=%b exp=01", {bus.done, bus.busy});
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin
            failures++; $display("FAIL b2b_second_done got=%b exp=1", bus.done);
        end
    endtask

    task automatic test_rotate_illegal();
        run_cmd(3'd2, 4'd0, 8'h81, 1'b0);
        run_cmd(3'd7, 4'd3, 8'h00, 1'b0);
`ifdef SEQ_ROTATE_EN
        checks++;
        if ({lat[7:0], got_result, got_err} !== {8'd5, 8'h0C, 1'b0}) begin
            failures++; $display("FAIL op7_rol got lat=%0d res=%h err=%b exp 5 0c 0", lat, got_result, got_err);
        end
`else
        checks++;
        if ({lat[7:0], got_result, got_err} !== {8'd2, 8'h81, 1'b1}) begin
            failures++; $display("FAIL op7_illegal got lat=%0d res=%h err=%b exp 2 81 1", lat, got_result, got_err);
        end
`endif
        run_cmd(3'd6, 4'd5, 8'h00, 1'b0);
        checks++;
        if ({lat[7:0], got_err} !== {8'd2, 1'b1}) begin
            failures++; $display("FAIL op6_illegal got lat=%0d err=%b exp 2 1", lat, got_err);
        end
        run_cmd(3'd0, 4'd7, 8'h00, 1'b0);
        checks++;
        if ({lat[7:0], got_err} !== {8'd2, 1'b0}) begin
            failures++; $display("FAIL nop got lat=%0d err=%b exp 2 0", lat, got_err);
        end
    endtask

    task automatic test_clear_maxcnt();
        run_cmd(3'd1, 4'd9, 8'hFF, 1'b0);
        checks++;
        if ({lat[7:0], got_result} !== {8'd3, 8'h00}) begin
            failures++; $display("FAIL clr_cmd got lat=%0d res=%h exp 3 00", lat, got_result);
        end
        run_cmd(3'd2, 4'd0, 8'h01, 1'b0);
        run_cmd(3'd3, 4'd15, 8'h00, 1'b0);
        checks++;
        if ({lat[7:0], got_result, got_cap} !== {8'd17, 8'h00, 8'h80}) begin
            failures++; $display("FAIL shl15 got lat=%0d res=%h cap=%h exp 17 00 80", lat, got_result, got_cap);
        end
    endtask

    task automatic test_abort();
        logic done_seen;
        run_cmd(3'd2, 4'd0, 8'h5A, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4; bus.cmd_cnt = 4'd8; bus.cmd_sin = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, reg_clr, reg_shift_r} !== 4'b0010) begin
            failures++; $display("FAIL abort_in_clr got=%b exp=0010", {bus.busy, bus.done, reg_clr, reg_shift_r});
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.busy, bus.result, bus.cap, reg_dout} !== {2'b10, 24'h000000}) begin
            failures++; $display("FAIL abort_after got rdy=%b busy=%b res=%h cap=%h reg=%h exp 1 0 00 00 00",
                                 bus.cmd_ready, bus.busy, bus.result, bus.cap, reg_dout);
        end
        done_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            failures++; $display("FAIL abort_no_done got=%b exp=0", done_seen);
        end
        checks++;
        if (multi_ctrl_seen !== 1'b0) begin
            failures++; $display("FAIL ctrl_onehot got=%b exp=0", multi_ctrl_seen);
        end
    endtask

    initial begin
        test_reset();
        test_load_shr();
        test_asr();
        test_shl();
        test_back_to_back();
        test_rotate_illegal();
        test_clear_maxcnt();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
